// File: rtl/buff_pkg.sv
// Shared definitions for the static circular buffer and its read-side
// controller: FSM state encoding, default geometry and the occupancy width
// helper. Both sides of the buffer import this so their geometry agrees.
package buff_pkg;

  localparam int NUMELEM_DEF = 4;
  localparam int BITDATA_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // Index width for a buffer of n elements; occupancy needs one bit more
  // so that the full count n is representable.
  function automatic int bitelem(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/buff_reader_skid2.sv
// skid2: two-entry in-order valid/ready skid buffer.
//   clk       clock
//   rst       synchronous active-low reset (empties the buffer)
//   clr       synchronous clear (empties the buffer)
//   in_valid  write strobe; the caller only writes when cnt < 2
//   in_data   write data
//   out_ready consumer ready
//   out_valid an entry is available (cnt != 0)
//   out_data  oldest entry, zero when empty
//   cnt       number of stored entries (0..2)
module skid2 #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        cnt
);

  logic [DATA_W-1:0] ent0_q;  // oldest
  logic [DATA_W-1:0] ent1_q;
  logic [1:0]        cnt_q;
  logic              take;
  logic              give;

  assign give = (cnt_q != 2'd0) && out_ready;
  assign take = in_valid && (cnt_q != 2'd2);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_q + 2'(take) - 2'(give);
    end
  end

  // Entry storage carries no reset; cnt_q alone decides what is live.
  always_ff @(posedge clk) begin
    case (cnt_q)
      2'd0: if (take) ent0_q <= in_data;
      2'd1: begin
        if (take && give) ent0_q <= in_data;
        else if (take) ent1_q <= in_data;
      end
      2'd2: if (give) ent0_q <= ent1_q;
      default: ;
    endcase
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? ent0_q : '0;
  assign cnt       = cnt_q;

endmodule

// File: rtl/buff_reader.sv
// buff_reader: read-side controller for the static circular buffer.
// Tracks buffer occupancy by snooping the writer's push strobe, pops only
// when data is present, grants the writer a space credit and streams data
// out through a two-entry skid with watermark/timeout release and flush.
//   clk          clock
//   rst          synchronous active-low reset
//   buf_push     writer push strobe (snooped)
//   buf_pop      pop strobe to the buffer (registers only, no m_ready path)
//   buf_dout     buffer head data, valid alongside buf_pop
//   space_avail  writer may push this cycle
//   m_valid/m_ready/m_data  output stream
//   flush        discard all stored data
//   flush_done   one-cycle pulse as the drain completes
//   err          sticky protocol-violation flag
//   occ          tracked buffer occupancy
//   state        FSM state (debug)
module buff_reader
  import buff_pkg::*;
#(
  parameter int NUMELEM = NUMELEM_DEF,
  parameter int BITDATA = BITDATA_DEF,
  parameter int WMARK   = 2,
  parameter int TIMEOUT = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           buf_push,
  output logic                           buf_pop,
  input  logic [BITDATA-1:0]             buf_dout,
  output logic                           space_avail,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [BITDATA-1:0]             m_data,
  input  logic                           flush,
  output logic                           flush_done,
  output logic                           err,
  output logic [bitelem(NUMELEM):0]      occ,
  output logic [1:0]                     state
);

  localparam int BITELEM = bitelem(NUMELEM);
  localparam int OCC_W   = BITELEM + 1;
  localparam int TMR_W   = $clog2(TIMEOUT) + 1;
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(NUMELEM);
  localparam logic [OCC_W-1:0] OCC_WMARK = OCC_W'(WMARK);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

  state_t             state_q;
  state_t             state_d;
  logic [OCC_W-1:0]   occ_q;
  logic [TMR_W-1:0]   timer_q;
  logic               err_q;
  logic [1:0]         skid_cnt;
  logic               skid_push;
  logic               skid_clr;

  always_comb begin
    buf_pop = 1'b0;
    case (state_q)
      STREAM:  buf_pop = (occ_q != '0) && (skid_cnt != 2'd2);
      DRAIN:   buf_pop = (occ_q != '0);
      default: buf_pop = 1'b0;
    endcase
  end

  assign space_avail = rst && (occ_q < OCC_FULL) && (state_q != DRAIN);
  assign flush_done  = (state_q == DRAIN) && (occ_q == '0);

  // Popped data enters the skid while streaming and is dropped while
  // draining. A flush empties the skid on the same edge that enters DRAIN.
  assign skid_push = buf_pop && (state_q == STREAM);
  assign skid_clr  = flush && (state_q != DRAIN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (occ_q != '0) state_d = FILL;
      FILL:   if ((occ_q >= OCC_WMARK) || (occ_q == OCC_FULL) || (timer_q == TMR_LAST))
                state_d = STREAM;
      STREAM: if ((occ_q == '0) && (skid_cnt == 2'd0) && !buf_push) state_d = IDLE;
      DRAIN:  if (occ_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush && (state_q != DRAIN)) state_d = DRAIN;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      occ_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_q + OCC_W'(buf_push) - OCC_W'(buf_pop);
      // Outside FILL the timer rests at zero, so it starts from zero on entry.
      timer_q <= (state_q == FILL) ? timer_q + 1'b1 : '0;
      err_q   <= err_q | (buf_push && !space_avail) | (buf_pop && (occ_q == '0));
    end
  end

  skid2 #(.DATA_W(BITDATA)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr       (skid_clr),
    .in_valid  (skid_push),
    .in_data   (buf_dout),
    .out_ready (m_ready),
    .out_valid (m_valid),
    .out_data  (m_data),
    .cnt       (skid_cnt)
  );

  assign err   = err_q;
  assign occ   = occ_q;
  assign state = state_q;

endmodule

// File: tb/tb_buff_reader.sv
module tb_buff_reader;
  import buff_pkg::*;

  localparam int N  = 4;
  localparam int BD = 4;
  localparam int WM = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          buf_push = 1'b0;
  logic          buf_pop;
  logic [BD-1:0] buf_dout = '0;
  logic          space_avail;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [BD-1:0] m_data;
  logic          flush = 1'b0;
  logic          flush_done;
  logic          err;
  logic [2:0]    occ;
  logic [1:0]    state;

  logic [BD-1:0] wdata = '0;

  buff_reader #(.NUMELEM(N), .BITDATA(BD), .WMARK(WM), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .buf_push    (buf_push),
    .buf_pop     (buf_pop),
    .buf_dout    (buf_dout),
    .space_avail (space_avail),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .flush       (flush),
    .flush_done  (flush_done),
    .err         (err),
    .occ         (occ),
    .state       (state)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the buffer itself as a queue, the expected output
  // order as a second queue, plus a draining flag and a sticky error.
  logic [BD-1:0] bufq[$];
  logic [BD-1:0] expq[$];
  bit draining = 0;
  bit err_exp  = 0;
  bit sb_en    = 1;
  int hs_cnt = 0, pop_cnt = 0, fd_cnt = 0, mv_cnt = 0;

  typedef struct {
    logic          push;
    logic [BD-1:0] d;
    logic [1:0]    st;
    logic [2:0]    occ;
    logic          pop;
    logic          mv;
    logic [BD-1:0] md;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit p, input logic [BD-1:0] d, input bit r, input bit f);
    buf_push = p;
    wdata    = d;
    m_ready  = r;
    flush    = f;
    #1;
  endtask

  // Called one unit after a negedge with inputs applied; checks the model,
  // advances it across the next posedge and returns at the following negedge.
  task automatic tick();
    bit sa;
    bit fl_acc;
    if (!rst) begin
      bufq.delete();
      expq.delete();
      draining = 0;
      err_exp  = 0;
    end else begin
      sa = !draining && (bufq.size() < N);
      if (sb_en) begin
        chk("occ", occ, bufq.size());
        chk("space_avail", space_avail, sa);
        chk("flush_done", flush_done, draining && (bufq.size() == 0));
        chk("err", err, err_exp);
        if (bufq.size() == 0) chk("pop_on_empty", buf_pop, 0);
        if (draining) chk("m_valid_in_drain", m_valid, 0);
        if (m_valid && m_ready) begin
          if (expq.size() == 0) chk("unexpected_output", m_valid, 0);
          else chk("m_data_order", m_data, expq.pop_front());
        end
      end
      if (m_valid && m_ready) hs_cnt++;
      if (buf_pop) pop_cnt++;
      if (flush_done) fd_cnt++;
      if (m_valid) mv_cnt++;
      if (buf_push && !sa) err_exp = 1;
      fl_acc = flush && !draining;
      if (draining && bufq.size() == 0) draining = 0;
      if (buf_pop && bufq.size() != 0) void'(bufq.pop_front());
      if (buf_push && sa) begin
        bufq.push_back(wdata);
        expq.push_back(wdata);
      end
      if (fl_acc) begin
        draining = 1;
        expq.delete();
      end
    end
    @(posedge clk);
    #1;
    buf_dout = (bufq.size() != 0) ? bufq[0] : '0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input bit r);
    bit done = 0;
    for (int k = 0; k < 100; k++) begin
      drive(0, '0, r, 0);
      if (state == 2'(IDLE) && bufq.size() == 0 && expq.size() == 0) begin
        done = 1;
        break;
      end
      tick();
    end
    chk(name, done, 1);
  endtask

  initial begin
    vec_t vecs[9];
    int   fill;
    bit   seen_stream;
    int   guard;

    @(negedge clk);

    // Reset held for three cycles: every output low.
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 0, 0);
      tick();
      chk("reset_outputs",
          {m_valid, m_data, buf_pop, flush_done, err, space_avail, occ, state}, 0);
    end
    rst = 1'b1;
    drive(0, '0, 0, 0);
    chk("post_reset_space", space_avail, 1);
    chk("post_reset_state", state, 2'(IDLE));
    tick();

    // Back-to-back A, B, C with m_ready high: cycle-exact table.
    vecs[0] = '{1, 4'hA, 2'(IDLE),   3'd0, 0, 0, 4'h0};
    vecs[1] = '{1, 4'hB, 2'(IDLE),   3'd1, 0, 0, 4'h0};
    vecs[2] = '{1, 4'hC, 2'(FILL),   3'd2, 0, 0, 4'h0};
    vecs[3] = '{0, 4'h0, 2'(STREAM), 3'd3, 1, 0, 4'h0};
    vecs[4] = '{0, 4'h0, 2'(STREAM), 3'd2, 1, 1, 4'hA};
    vecs[5] = '{0, 4'h0, 2'(STREAM), 3'd1, 1, 1, 4'hB};
    vecs[6] = '{0, 4'h0, 2'(STREAM), 3'd0, 0, 1, 4'hC};
    vecs[7] = '{0, 4'h0, 2'(STREAM), 3'd0, 0, 0, 4'h0};
    vecs[8] = '{0, 4'h0, 2'(IDLE),   3'd0, 0, 0, 4'h0};
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].push, vecs[i].d, 1, 0);
      chk($sformatf("vec%0d_state", i), state, vecs[i].st);
      chk($sformatf("vec%0d_occ", i), occ, vecs[i].occ);
      chk($sformatf("vec%0d_pop", i), buf_pop, vecs[i].pop);
      chk($sformatf("vec%0d_mvalid", i), m_valid, vecs[i].mv);
      if (vecs[i].mv) chk($sformatf("vec%0d_mdata", i), m_data, vecs[i].md);
      tick();
    end

    // Single push: released by the FILL timeout.
    hs_cnt = 0;
    fill = 0;
    seen_stream = 0;
    drive(1, 4'h5, 1, 0);
    tick();
    for (int k = 0; k < 60; k++) begin
      drive(0, '0, 1, 0);
      if (state == 2'(FILL)) fill++;
      if (state == 2'(STREAM)) seen_stream = 1;
      if (seen_stream && state == 2'(IDLE)) break;
      tick();
    end
    chk("timeout_fill_cycles", fill, TO);
    chk("timeout_outputs", hs_cnt, 1);
    chk("timeout_idle", state, 2'(IDLE));

    // Stalled consumer while four items arrive, then a continuous run.
    hs_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, BD'(i + 1), 0, 0);
      tick();
    end
    drive(0, '0, 0, 0);
    tick();
    drive(0, '0, 0, 0);
    chk("stall_occ", occ, 2);
    chk("stall_pop", buf_pop, 0);
    chk("stall_space", space_avail, 1);
    chk("stall_head", m_data, 4'h1);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, BD'(i + 5), 1, 0);
      tick();
    end
    wait_idle("stall_run_idle", 1);
    chk("stall_run_count", hs_cnt, 14);

    // Flush with three items held in FILL.
    pop_cnt = 0;
    fd_cnt = 0;
    mv_cnt = 0;
    drive(1, 4'h7, 1, 0);
    tick();
    drive(1, 4'h8, 1, 0);
    tick();
    drive(1, 4'h9, 1, 1);
    chk("flush_from_fill", state, 2'(FILL));
    tick();
    drive(0, '0, 1, 0);
    chk("drain_entered", state, 2'(DRAIN));
    chk("drain_space", space_avail, 0);
    wait_idle("drain_idle", 1);
    chk("drain_pops", pop_cnt, 3);
    chk("drain_done_pulses", fd_cnt, 1);
    chk("drain_no_valid", mv_cnt, 0);

    // Randomised traffic against the model; the writer honours space_avail.
    for (int k = 0; k < 2000; k++) begin
      drive(($urandom_range(0, 3) != 0) && space_avail, BD'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
      tick();
    end
    wait_idle("random_idle", 1);

    // Overfill: a push at full occupancy raises a sticky err.
    guard = 0;
    while (space_avail && guard < 12) begin
      drive(1, BD'(guard), 0, 0);
      tick();
      guard++;
    end
    drive(0, '0, 0, 0);
    chk("full_occ", occ, N);
    sb_en = 0;
    drive(1, 4'hF, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 1, 0);
      chk("err_sticky", err, 1);
      tick();
    end
    rst = 1'b0;
    drive(0, '0, 0, 0);
    tick();
    chk("err_cleared", err, 0);
    chk("reset_midop_valid", m_valid, 0);
    rst = 1'b1;
    sb_en = 1;
    drive(0, '0, 0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/buff_reader.md
Name: buff_reader

Overview:
- Read-side controller for the static circular buffer.
- Snoops the writer's push strobe to track occupancy, because the buffer exposes no full/empty flags.
- Issues pops only when the buffer is non-empty, and gives the writer a space credit.
- Presents buffered data on a valid/ready output stream through a 2-entry skid stage, with watermark/timeout release and a flush (drain) facility.

Parameters:
- NUMELEM, 4: buffer depth; must match the attached buffer.
- BITDATA, 4: element width.
- WMARK, 2: occupancy that releases FILL into STREAM; 1..NUMELEM.
- TIMEOUT, 8: cycles in FILL before forced release; ≥1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset (rst==0 resets).
- buf_push  in  1  writer's push strobe to the buffer (snooped).
- buf_pop  out  1  pop strobe to the buffer.
- buf_dout  in  BITDATA  buffer head data; valid in the same cycle as buf_pop.
- space_avail  out  1  writer may push this cycle.
- m_valid  out  1  output stream valid.
- m_ready  in  1  output stream ready.
- m_data  out  BITDATA  output stream data.
- flush  in  1  request to discard all stored data.
- flush_done  out  1  one-cycle pulse when the drain completes.
- err  out  1  sticky protocol-violation flag.
- occ  out  $clog2(NUMELEM)+1  tracked buffer occupancy.
- state  out  2  FSM state (debug).

Behaviour:
- Reset (rst==0): occ=0, state=IDLE, skid empty, m_valid=0, m_data=0, buf_pop=0, flush_done=0, err=0, space_avail=0.
- space_avail = rst && (occ<NUMELEM) && state!=DRAIN. Combinational from registers.
- occ_next = occ + buf_push - buf_pop. Width BITELEM+1, never wraps in legal operation.
- buf_pop is combinational from registers only; no path from m_ready.
  - STREAM: buf_pop = (occ!=0) && (skid_cnt<2).
  - DRAIN: buf_pop = (occ!=0).
  - IDLE/FILL: buf_pop = 0.
- On a pop, buf_dout is captured into the skid in the same cycle (STREAM) or discarded (DRAIN).
- Skid stage (2 entries, in-order):
  - skid_cnt_next = skid_cnt + (pop in STREAM) - (m_valid && m_ready).
  - m_valid = skid_cnt!=0; m_data = oldest entry.
  - m_data is held stable while m_valid && !m_ready.
- FSM (registered transitions, evaluated on current-cycle registers):
  - IDLE: go to FILL when occ!=0.
  - FILL: timer increments each cycle, cleared on entry.
    - Go to STREAM when occ>=WMARK, or occ==NUMELEM, or timer==TIMEOUT-1.
  - STREAM: go to IDLE when occ==0 && skid_cnt==0 && !buf_push.
  - Any non-DRAIN state + flush: go to DRAIN. Skid is cleared on the transition edge, so m_valid=0 the next cycle.
  - DRAIN: pop every cycle while occ!=0; flush is ignored.
    - When occ==0, go to IDLE and pulse flush_done for exactly that one cycle.
- Flush has priority over all other transitions in the same cycle.
- err is set (sticky until reset) on any of:
  - buf_push while space_avail==0.
  - buf_pop while occ==0 (internal invariant).
- Push and pop in the same cycle: occ unchanged. This is legal at occ==NUMELEM only if space_avail was 1, i.e. never; at occ==NUMELEM the push sets err.
- Latency with back-to-back pushes from IDLE, WMARK=2: first push at t0, STREAM at t3, first pop at t3, m_valid at t4.
- Wrap-around is internal to the buffer; ordering is preserved across it.
- Reset mid-operation discards all skid contents immediately. The buffer must be reset in the same cycle, with the top level adapting polarity.

Decomposition:
- Shared package buff_pkg holds:
  - state enum: IDLE=0, FILL=1, STREAM=2, DRAIN=3.
  - BITELEM derivation.
  - shared NUMELEM/BITDATA defaults, common with the buffer.
- One sub-module, skid2: 2-entry valid/ready skid buffer with a synchronous clear input.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 during reset; space_avail=1 in the first post-reset cycle; state=IDLE.
- Pushes 0xA, 0xB, 0xC at t0..t2, m_ready=1 -> STREAM at t3; m_data A, B, C on m_valid at t4, t5, t6; returns to IDLE; err=0.
- Single push of 0x5, no more -> FILL for TIMEOUT cycles, then STREAM; m_data=0x5 once; occ returns to 0.
- m_ready=0 while 4 items are pushed -> two pops fill the skid; occ=2; buf_pop=0; space_avail=1. Then m_ready=1 and 10 further continuous pushes -> all 14 values in order, exercising buffer wrap.
- 3 items stored in FILL, flush pulse -> DRAIN; space_avail=0; no m_valid; 3 pops; flush_done single pulse; occ=0; IDLE.
- Push at occ==NUMELEM -> err=1 and stays 1 until rst==0.
